imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter INST_WIDTH, default 32, instruction word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, PC width.
REQ-003 SHALL have port clock, input, 1: the only clock; all state updates on posedge clock.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low; reset==0 at posedge clock resets the block.
REQ-005 SHALL have ports req0_valid / req1_valid, input, 1 each: requester N presents a fetch request.
REQ-006 SHALL have ports req0_pc / req1_pc, input, ADDR_WIDTH each: requester N fetch address.
REQ-007 SHALL have ports req0_ready / req1_ready, output, 1 each: requester N request accepted this cycle.
REQ-008 SHALL have ports rsp0_valid / rsp1_valid, output, 1 each: requester N response word valid this cycle.
REQ-009 SHALL have ports rsp0_inst / rsp1_inst, output, INST_WIDTH each: response word.
REQ-010 SHALL have ports kill0 / kill1, input, 1 each: cancel requester N in-flight response (redirect).
REQ-011 SHALL have port mem_valid, output, 1: request to the memory.
REQ-012 SHALL have port mem_pc, output, ADDR_WIDTH: address to the memory.
REQ-013 SHALL have port mem_ready, input, 1: memory accepts the request this cycle.
REQ-014 SHALL have port mem_inst, input, INST_WIDTH: memory word, registered; valid one cycle after acceptance.
REQ-015 SHALL have ports grant_cnt0 / grant_cnt1, output, 32 each: accepted-request counters.

Function
REQ-016 SHALL treat a handshake as mem_valid && mem_ready; at most one handshake per cycle.
REQ-017 SHALL drive mem_valid = req0_valid || req1_valid, combinationally.
REQ-018 SHALL choose the winner as follows: sole valid requester wins; if both are valid, the requester named by rr_ptr wins.
REQ-019 SHALL drive mem_pc from the winner's pc; if no requester is valid, mem_pc SHALL be the req0_pc value.
REQ-020 SHALL assert reqN_ready = mem_ready && winner==N; the loser's ready SHALL be 0.
REQ-021 SHALL toggle rr_ptr to the other requester on every handshake where both were valid; otherwise rr_ptr holds.
REQ-022 SHALL run a two-state FSM: IDLE (nothing in flight) and PEND (one response due this cycle).
REQ-023 SHALL transition IDLE->PEND on a handshake, PEND->PEND on a handshake, PEND->IDLE on no handshake; IDLE SHALL hold otherwise.
REQ-024 SHALL record owner and a live bit on each handshake; live SHALL be cleared at once by killN when owner==N in the same cycle.
REQ-025 SHALL, in PEND, assert rsp<owner>_valid=1 for exactly one cycle with rsp<owner>_inst=mem_inst, only if live=1 and kill<owner>=0 this cycle.
REQ-026 SHALL drive rspN_inst to the mem_inst value whenever rspN_valid=0.
REQ-027 SHALL sustain one request per cycle, back-to-back; a response in PEND and a new handshake SHALL coexist.
REQ-028 SHALL NOT cancel a new request by kill; killN SHALL affect only the response already in flight.
REQ-029 SHALL increment grant_cntN by 1 on each handshake granted to N, wrapping 0xFFFFFFFF->0.
REQ-030 SHALL, while mem_ready=0, keep requests pending, keep rr_ptr, and keep both readys low.

Reset
REQ-031 SHALL, on reset==0, set state=IDLE, live=0, owner=0, rr_ptr=0, and grant_cnt0 = grant_cnt1 = 0.
REQ-032 SHALL hold rsp0_valid = rsp1_valid = 0 in the cycle after reset; mem_valid is combinational and SHALL follow the inputs.
REQ-033 SHALL discard an in-flight response when reset is asserted mid-operation.

Structure
REQ-034 SHALL place in a shared package: the FSM state enum (IDLE, PEND), the requester-id typedef (1 bit), and the REQ_IDLE constant.
REQ-035 SHALL be a single module; a round-robin pick sub-module is optional, named rr_pick2.

Verification
REQ-036 Bench SHALL cover: req0 only, pc=0x8000_0000, mem_ready=1, mem returns 0x0000_0013 -> req0_ready=1 at T, rsp0_valid=1 with 0x13 at T+1, grant_cnt0=1.
REQ-037 Bench SHALL cover: both valid for 4 cycles after reset -> grant order 0,1,0,1 and grant_cnt0 = grant_cnt1 = 2.
REQ-038 Bench SHALL cover: req0 handshake at T, kill0=1 at T+1 -> rsp0_valid=0 at T+1; req1 handshake at T+1 -> rsp1_valid=1 at T+2.
REQ-039 Bench SHALL cover: mem_ready=0 for 3 cycles with both valid -> no readys asserted and rr_ptr unchanged; first grant after release goes to 0.
REQ-040 Bench SHALL cover: reset=0 driven while PEND -> rsp valid=0 next cycle, state IDLE, counters 0.
REQ-041 Bench SHALL cover: grant_cnt1 forced to 0xFFFF_FFFF, then one req1 handshake -> grant_cnt1=0.

Source files
------------

// File: rtl/imem_arbiter_pkg.sv
// Shared types and constants for the two-requester instruction-memory arbiter.
package imem_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    typedef logic req_id_t;

    // Default winner when nobody requests; mem_pc then reflects req0_pc.
    localparam req_id_t REQ_IDLE = 1'b0;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a sole requester wins, a tie goes to the pointer.
module rr_pick2
    import imem_arbiter_pkg::*;
(
    input  logic    valid0_i,
    input  logic    valid1_i,
    input  req_id_t rr_ptr_i,
    output req_id_t winner_o,
    output logic    both_o
);

    assign both_o = valid0_i && valid1_i;

    always_comb begin
        // NOTE: default first so every path assigns winner_o and no latch is inferred.
        winner_o = REQ_IDLE;
        if (both_o) begin
            winner_o = rr_ptr_i;
        end else if (valid1_i) begin
            winner_o = 1'b1;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates two fetch requesters onto one pipelined instruction memory and
// steers the registered memory word back to the requester that issued it.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req0_pc,
    input  logic [ADDR_WIDTH-1:0] req1_pc,
    output logic                  req0_ready,
    output logic                  req1_ready,
    output logic                  rsp0_valid,
    output logic                  rsp1_valid,
    output logic [INST_WIDTH-1:0] rsp0_inst,
    output logic [INST_WIDTH-1:0] rsp1_inst,
    input  logic                  kill0,
    input  logic                  kill1,
    output logic                  mem_valid,
    output logic [ADDR_WIDTH-1:0] mem_pc,
    input  logic                  mem_ready,
    input  logic [INST_WIDTH-1:0] mem_inst,
    output logic [31:0]           grant_cnt0,
    output logic [31:0]           grant_cnt1
);

    state_t  state_q, state_d;
    req_id_t owner_q, owner_d;
    logic    live_q, live_d;
    req_id_t rr_ptr_q, rr_ptr_d;
    logic [31:0] grant_cnt0_q, grant_cnt1_q;
    logic [31:0] grant_cnt0_d, grant_cnt1_d;

    req_id_t winner;
    logic    both;
    logic    handshake;
    logic    owner_kill;

    rr_pick2 u_pick (
        .valid0_i (req0_valid),
        .valid1_i (req1_valid),
        .rr_ptr_i (rr_ptr_q),
        .winner_o (winner),
        .both_o   (both)
    );

    assign mem_valid  = req0_valid || req1_valid;
    assign mem_pc     = (winner == 1'b1) ? req1_pc : req0_pc;
    assign handshake  = mem_valid && mem_ready;
    assign req0_ready = handshake && (winner == 1'b0);
    assign req1_ready = handshake && (winner == 1'b1);

    assign owner_kill = (owner_q == 1'b1) ? kill1 : kill0;

    // The response goes out only in the cycle the word arrives, and only if
    // no redirect has cancelled it up to and including that cycle.
    assign rsp0_valid = (state_q == PEND) && live_q && !owner_kill && (owner_q == 1'b0);
    assign rsp1_valid = (state_q == PEND) && live_q && !owner_kill && (owner_q == 1'b1);
    assign rsp0_inst  = mem_inst;
    assign rsp1_inst  = mem_inst;

    assign grant_cnt0_d = grant_cnt0_q + 32'(req0_ready);
    assign grant_cnt1_d = grant_cnt1_q + 32'(req1_ready);
    assign grant_cnt0   = grant_cnt0_q;
    assign grant_cnt1   = grant_cnt1_q;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        live_d   = live_q;
        rr_ptr_d = rr_ptr_q;

        if (handshake && both) begin
            rr_ptr_d = ~rr_ptr_q;
        end

        // A new handshake always wins over a kill: kill only targets the word in flight.
        if (handshake) begin
            state_d = PEND;
            owner_d = winner;
            live_d  = 1'b1;
        end else begin
            state_d = IDLE;
            live_d  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            live_q       <= 1'b0;
            rr_ptr_q     <= 1'b0;
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            owner_q      <= owner_d;
            live_q       <= live_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed self-checking bench for imem_arbiter.
module tb_imem_arbiter;
    import imem_arbiter_pkg::*;

    logic        clock;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_pc, req1_pc;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_inst, rsp1_inst;
    logic        kill0, kill1;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_ready;
    logic [31:0] mem_inst;
    logic [31:0] grant_cnt0, grant_cnt1;

    int tests_run = 0;
    int tests_failed = 0;

    imem_arbiter #(.INST_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_pc    (req0_pc),
        .req1_pc    (req1_pc),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp0_inst  (rsp0_inst),
        .rsp1_inst  (rsp1_inst),
        .kill0      (kill0),
        .kill1      (kill1),
        .mem_valid  (mem_valid),
        .mem_pc     (mem_pc),
        .mem_ready  (mem_ready),
        .mem_inst   (mem_inst),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_pc    = '0;
        req1_pc    = '0;
        kill0      = 1'b0;
        kill1      = 1'b0;
        mem_ready  = 1'b0;
        mem_inst   = '0;

        // Reset state
        step();
        step();
        reset = 1'b1;
        #1;
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        check("rst_rr", 32'(dut.rr_ptr_q), 32'd0);
        check("rst_cnt0", grant_cnt0, 32'd0);
        check("rst_cnt1", grant_cnt1, 32'd0);
        check("rst_rsp0", 32'(rsp0_valid), 32'd0);
        check("rst_rsp1", 32'(rsp1_valid), 32'd0);
        check("rst_memv", 32'(mem_valid), 32'd0);

        // Single req0 fetch and its response one cycle later
        req0_valid = 1'b1;
        req0_pc    = 32'h8000_0000;
        mem_ready  = 1'b1;
        #1;
        check("s_ready0", 32'(req0_ready), 32'd1);
        check("s_ready1", 32'(req1_ready), 32'd0);
        check("s_mempc", mem_pc, 32'h8000_0000);
        step();
        req0_valid = 1'b0;
        mem_inst   = 32'h0000_0013;
        #1;
        check("s_rsp0v", 32'(rsp0_valid), 32'd1);
        check("s_rsp0i", rsp0_inst, 32'h0000_0013);
        check("s_rsp1v", 32'(rsp1_valid), 32'd0);
        check("s_cnt0", grant_cnt0, 32'd1);
        step();
        check("s_idle", 32'(dut.state_q), 32'(IDLE));
        check("s_rsp0_off", 32'(rsp0_valid), 32'd0);

        // Both valid for four cycles after reset: grants alternate 0,1,0,1
        reset = 1'b0;
        step();
        reset      = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_pc    = 32'h0000_0100;
        req1_pc    = 32'h0000_0200;
        mem_inst   = 32'h0000_1111;
        #1;
        check("rr_ready0_c0", 32'(req0_ready), 32'd1);
        check("rr_ready1_c0", 32'(req1_ready), 32'd0);
        check("rr_pc_c0", mem_pc, 32'h0000_0100);
        step();
        check("rr_ready0_c1", 32'(req0_ready), 32'd0);
        check("rr_ready1_c1", 32'(req1_ready), 32'd1);
        check("rr_pc_c1", mem_pc, 32'h0000_0200);
        check("rr_rsp0_c1", 32'(rsp0_valid), 32'd1);
        step();
        check("rr_ready0_c2", 32'(req0_ready), 32'd1);
        check("rr_rsp1_c2", 32'(rsp1_valid), 32'd1);
        check("rr_rsp0_c2", 32'(rsp0_valid), 32'd0);
        step();
        check("rr_ready1_c3", 32'(req1_ready), 32'd1);
        check("rr_pc_c3", mem_pc, 32'h0000_0200);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        mem_inst   = 32'h0000_2222;
        #1;
        check("rr_cnt0", grant_cnt0, 32'd2);
        check("rr_cnt1", grant_cnt1, 32'd2);
        check("rr_ptr_back", 32'(dut.rr_ptr_q), 32'd0);
        check("rr_last_rsp1", 32'(rsp1_valid), 32'd1);
        check("rr_last_inst", rsp1_inst, 32'h0000_2222);

        // Kill of req0 word while req1 handshakes in the same cycle
        step();
        req0_valid = 1'b1;
        req0_pc    = 32'h0000_0300;
        #1;
        check("k_ready0_T", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_pc    = 32'h0000_0400;
        kill0      = 1'b1;
        mem_inst   = 32'h0000_AAAA;
        #1;
        check("k_rsp0_T1", 32'(rsp0_valid), 32'd0);
        check("k_ready1_T1", 32'(req1_ready), 32'd1);
        check("k_pc_T1", mem_pc, 32'h0000_0400);
        step();
        req1_valid = 1'b0;
        kill0      = 1'b0;
        mem_inst   = 32'h0000_BBBB;
        #1;
        check("k_rsp1_T2", 32'(rsp1_valid), 32'd1);
        check("k_rsp1i_T2", rsp1_inst, 32'h0000_BBBB);
        check("k_rsp0_T2", 32'(rsp0_valid), 32'd0);
        check("k_cnt0", grant_cnt0, 32'd3);
        check("k_cnt1", grant_cnt1, 32'd3);

        // Memory stall with both requesting: nothing accepted, pointer holds
        step();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        mem_ready  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("st_ready0", 32'(req0_ready), 32'd0);
            check("st_ready1", 32'(req1_ready), 32'd0);
            step();
            check("st_rr", 32'(dut.rr_ptr_q), 32'd0);
            check("st_rsp1", 32'(rsp1_valid), 32'd0);
        end
        mem_ready = 1'b1;
        #1;
        check("st_rel_ready0", 32'(req0_ready), 32'd1);
        check("st_rel_ready1", 32'(req1_ready), 32'd0);
        step();
        check("st_rel_rr", 32'(dut.rr_ptr_q), 32'd1);
        check("st_rel_pend", 32'(dut.state_q), 32'(PEND));

        // Reset asserted while a response is pending
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset      = 1'b0;
        step();
        check("r_rsp0", 32'(rsp0_valid), 32'd0);
        check("r_rsp1", 32'(rsp1_valid), 32'd0);
        check("r_state", 32'(dut.state_q), 32'(IDLE));
        check("r_cnt0", grant_cnt0, 32'd0);
        check("r_cnt1", grant_cnt1, 32'd0);
        check("r_rr", 32'(dut.rr_ptr_q), 32'd0);
        reset = 1'b1;

        // Counter wrap on req1
        force dut.grant_cnt1_d = 32'hFFFF_FFFF;
        step();
        release dut.grant_cnt1_d;
        #1;
        check("w_preload", grant_cnt1, 32'hFFFF_FFFF);
        req1_valid = 1'b1;
        req1_pc    = 32'h0000_0500;
        #1;
        check("w_ready1", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 1'b0;
        #1;
        check("w_cnt1", grant_cnt1, 32'd0);
        check("w_cnt0", grant_cnt0, 32'd0);
        check("w_rsp1", 32'(rsp1_valid), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
